// File: rtl/blk_ram_gen_dp_if.sv
// Bus bundle for blk_ram_gen_dp: both RAM ports plus the collision flag.
// The master side drives enables, addresses and write data; the RAM is the slave.
interface blk_ram_gen_dp_if #(
  parameter int unsigned AddrWidth = 12,
  parameter int unsigned DataWidth = 9
);
  logic                 ena;
  logic                 enb;
  logic                 wea;
  logic                 web;
  logic                 regcea;
  logic                 regceb;
  logic [AddrWidth-1:0] addra;
  logic [AddrWidth-1:0] addrb;
  logic [DataWidth-1:0] dina;
  logic [DataWidth-1:0] dinb;
  logic [DataWidth-1:0] douta;
  logic [DataWidth-1:0] doutb;
  logic [DataWidth-1:0] Regdouta;
  logic [DataWidth-1:0] Regdoutb;
  logic                 coll;

  modport master (
    output ena, enb, wea, web, regcea, regceb, addra, addrb, dina, dinb,
    input  douta, doutb, Regdouta, Regdoutb, coll
  );

  modport slave (
    input  ena, enb, wea, web, regcea, regceb, addra, addrb, dina, dinb,
    output douta, doutb, Regdouta, Regdoutb, coll
  );
endinterface

// File: rtl/blk_ram_gen_dp.sv
// Behavioural two-port block RAM with per-port output register and selectable write mode.
// Define BLKRAM_COLLISION_FLAG_EN to build the same-address write-collision flag.
module blk_ram_gen_dp #(
  parameter int unsigned AddrWidth = 12,
  parameter int unsigned DataWidth = 9,
  parameter int unsigned WriteMode = 0,
  parameter bit          InitZero  = 1'b1
) (
  input logic            clka,
  input logic            rsta_n,
  blk_ram_gen_dp_if.slave bus
);
  localparam int unsigned Depth = 2 ** AddrWidth;
  localparam logic [DataWidth-1:0] InitWord = InitZero ? '0 : 'x;

  logic [DataWidth-1:0] mem [Depth] = '{default: InitWord};

  logic                 wr_a, wr_b, same_addr;
  logic [DataWidth-1:0] douta_q, douta_d, doutb_q, doutb_d;
  logic [DataWidth-1:0] rega_q, regb_q;

  assign same_addr = (bus.addra == bus.addrb);
  assign wr_a      = bus.ena & bus.wea;
  // Port A wins a same-address dual write, so B's store is suppressed.
  assign wr_b      = bus.enb & bus.web & ~(wr_a & same_addr);

  always_ff @(posedge clka) begin
    if (rsta_n) begin
      if (wr_a) mem[bus.addra] <= bus.dina;
      if (wr_b) mem[bus.addrb] <= bus.dinb;
    end
  end

  // mem is read before the nonblocking update, giving read-before-write across ports.
  always_comb begin
    douta_d = douta_q;
    if (bus.ena) begin
      if (!bus.wea) begin
        douta_d = mem[bus.addra];
      end else begin
        case (WriteMode)
          32'd0:   douta_d = bus.dina;
          32'd1:   douta_d = mem[bus.addra];
          default: douta_d = douta_q;
        endcase
      end
    end
  end

  always_comb begin
    doutb_d = doutb_q;
    if (bus.enb) begin
      if (!bus.web) begin
        doutb_d = mem[bus.addrb];
      end else begin
        case (WriteMode)
          32'd0:   doutb_d = bus.dinb;
          32'd1:   doutb_d = mem[bus.addrb];
          default: doutb_d = doutb_q;
        endcase
      end
    end
  end

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      douta_q <= '0;
      doutb_q <= '0;
      rega_q  <= '0;
      regb_q  <= '0;
    end else begin
      douta_q <= douta_d;
      doutb_q <= doutb_d;
      if (bus.regcea) rega_q <= douta_q;
      if (bus.regceb) regb_q <= doutb_q;
    end
  end

  assign bus.douta    = douta_q;
  assign bus.doutb    = doutb_q;
  assign bus.Regdouta = rega_q;
  assign bus.Regdoutb = regb_q;

`ifdef BLKRAM_COLLISION_FLAG_EN
  logic coll_q, coll_d;

  assign coll_d = bus.ena & bus.enb & same_addr & (bus.wea | bus.web);

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      coll_q <= 1'b0;
    end else begin
      coll_q <= coll_d;
    end
  end

  assign bus.coll = coll_q;
`else
  assign bus.coll = 1'b0;
`endif
endmodule

// File: tb/tb_blk_ram_gen_dp.sv
// Directed self-checking bench for blk_ram_gen_dp: write modes, collisions, reset, small sweep.
module tb_blk_ram_gen_dp;
  logic clka = 1'b0;
  logic rsta_n = 1'b1;
  int   tests = 0;
  int   fails = 0;

`ifdef BLKRAM_COLLISION_FLAG_EN
  localparam bit ExpColl = 1'b1;
`else
  localparam bit ExpColl = 1'b0;
`endif

  always #5 clka = ~clka;

  blk_ram_gen_dp_if #(.AddrWidth(12), .DataWidth(9))  ifa ();
  blk_ram_gen_dp_if #(.AddrWidth(12), .DataWidth(9))  ifr ();
  blk_ram_gen_dp_if #(.AddrWidth(12), .DataWidth(9))  ifn ();
  blk_ram_gen_dp_if #(.AddrWidth(4),  .DataWidth(32)) ifs ();

  blk_ram_gen_dp #(.AddrWidth(12), .DataWidth(9), .WriteMode(0), .InitZero(1'b1)) dut (
    .clka(clka), .rsta_n(rsta_n), .bus(ifa)
  );
  blk_ram_gen_dp #(.AddrWidth(12), .DataWidth(9), .WriteMode(1), .InitZero(1'b1)) dut_rf (
    .clka(clka), .rsta_n(rsta_n), .bus(ifr)
  );
  blk_ram_gen_dp #(.AddrWidth(12), .DataWidth(9), .WriteMode(2), .InitZero(1'b1)) dut_nc (
    .clka(clka), .rsta_n(rsta_n), .bus(ifn)
  );
  blk_ram_gen_dp #(.AddrWidth(4), .DataWidth(32), .WriteMode(0), .InitZero(1'b1)) dut_sw (
    .clka(clka), .rsta_n(rsta_n), .bus(ifs)
  );

  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  task automatic idle_all();
    {ifa.ena, ifa.enb, ifa.wea, ifa.web, ifa.regcea, ifa.regceb} = '0;
    {ifr.ena, ifr.enb, ifr.wea, ifr.web, ifr.regcea, ifr.regceb} = '0;
    {ifn.ena, ifn.enb, ifn.wea, ifn.web, ifn.regcea, ifn.regceb} = '0;
    {ifs.ena, ifs.enb, ifs.wea, ifs.web, ifs.regcea, ifs.regceb} = '0;
    ifa.addra = '0; ifa.addrb = '0; ifa.dina = '0; ifa.dinb = '0;
    ifr.addra = '0; ifr.addrb = '0; ifr.dina = '0; ifr.dinb = '0;
    ifn.addra = '0; ifn.addrb = '0; ifn.dina = '0; ifn.dinb = '0;
    ifs.addra = '0; ifs.addrb = '0; ifs.dina = '0; ifs.dinb = '0;
  endtask

  task automatic test_reset();
    idle_all();
    #2 rsta_n = 1'b0;
    tick();
    tick();
    tests++; if (ifa.douta !== 9'h000) begin fails++; $display("FAIL reset_douta got %h exp 000", ifa.douta); end
    tests++; if (ifa.doutb !== 9'h000) begin fails++; $display("FAIL reset_doutb got %h exp 000", ifa.doutb); end
    tests++; if (ifa.Regdouta !== 9'h000) begin fails++; $display("FAIL reset_rega got %h exp 000", ifa.Regdouta); end
    tests++; if (ifa.Regdoutb !== 9'h000) begin fails++; $display("FAIL reset_regb got %h exp 000", ifa.Regdoutb); end
    tests++; if (ifa.coll !== 1'b0) begin fails++; $display("FAIL reset_coll got %b exp 0", ifa.coll); end
    rsta_n = 1'b1;
  endtask

  task automatic test_write_first();
    ifa.ena = 1'b1; ifa.wea = 1'b1; ifa.addra = 12'h005; ifa.dina = 9'h1A5; ifa.regcea = 1'b1;
    tick();
    tests++; if (ifa.douta !== 9'h1A5) begin fails++; $display("FAIL wf_write got %h exp 1a5", ifa.douta); end
    tests++; if (ifa.Regdouta !== 9'h000) begin fails++; $display("FAIL wf_reg_lag got %h exp 000", ifa.Regdouta); end
    ifa.wea = 1'b0;
    tick();
    tests++; if (ifa.douta !== 9'h1A5) begin fails++; $display("FAIL wf_read got %h exp 1a5", ifa.douta); end
    tests++; if (ifa.Regdouta !== 9'h1A5) begin fails++; $display("FAIL wf_reg got %h exp 1a5", ifa.Regdouta); end
    ifa.ena = 1'b0; ifa.regcea = 1'b0; ifa.dina = 9'h000;
    tick();
    tests++; if (ifa.douta !== 9'h1A5) begin fails++; $display("FAIL wf_en0_hold got %h exp 1a5", ifa.douta); end
  endtask

  task automatic test_write_modes();
    ifr.ena = 1'b1; ifr.wea = 1'b1; ifr.addra = 12'h012; ifr.dina = 9'h033;
    ifn.ena = 1'b1; ifn.wea = 1'b1; ifn.addra = 12'h012; ifn.dina = 9'h033;
    tick();
    ifr.addra = 12'h010; ifr.dina = 9'h055;
    ifn.addra = 12'h010; ifn.dina = 9'h055;
    tick();
    tests++; if (ifn.douta !== 9'h000) begin fails++; $display("FAIL nc_hold_init got %h exp 000", ifn.douta); end
    ifr.wea = 1'b0; ifr.addra = 12'h012;
    ifn.wea = 1'b0; ifn.addra = 12'h012;
    tick();
    tests++; if (ifn.douta !== 9'h033) begin fails++; $display("FAIL nc_prior got %h exp 033", ifn.douta); end
    ifr.wea = 1'b1; ifr.addra = 12'h010; ifr.dina = 9'h0AA;
    ifn.wea = 1'b1; ifn.addra = 12'h010; ifn.dina = 9'h0AA;
    tick();
    tests++; if (ifr.douta !== 9'h055) begin fails++; $display("FAIL rf_old got %h exp 055", ifr.douta); end
    tests++; if (ifn.douta !== 9'h033) begin fails++; $display("FAIL nc_keep got %h exp 033", ifn.douta); end
    ifr.wea = 1'b0;
    ifn.wea = 1'b0;
    tick();
    tests++; if (ifr.douta !== 9'h0AA) begin fails++; $display("FAIL rf_mem got %h exp 0aa", ifr.douta); end
    tests++; if (ifn.douta !== 9'h0AA) begin fails++; $display("FAIL nc_mem got %h exp 0aa", ifn.douta); end
    ifr.ena = 1'b0;
    ifn.ena = 1'b0;
  endtask

  task automatic test_dual_write();
    ifa.ena = 1'b1; ifa.wea = 1'b1; ifa.addra = 12'h3FF; ifa.dina = 9'h111;
    ifa.enb = 1'b1; ifa.web = 1'b1; ifa.addrb = 12'h3FF; ifa.dinb = 9'h0EE;
    tick();
    tests++; if (ifa.douta !== 9'h111) begin fails++; $display("FAIL dw_douta got %h exp 111", ifa.douta); end
    tests++; if (ifa.doutb !== 9'h0EE) begin fails++; $display("FAIL dw_doutb got %h exp 0ee", ifa.doutb); end
    tests++; if (ifa.coll !== ExpColl) begin fails++; $display("FAIL dw_coll got %b exp %b", ifa.coll, ExpColl); end
    ifa.wea = 1'b0; ifa.web = 1'b0;
    tick();
    tests++; if (ifa.douta !== 9'h111) begin fails++; $display("FAIL dw_read_a got %h exp 111", ifa.douta); end
    tests++; if (ifa.doutb !== 9'h111) begin fails++; $display("FAIL dw_read_b got %h exp 111", ifa.doutb); end
    tests++; if (ifa.coll !== 1'b0) begin fails++; $display("FAIL dw_coll_pulse got %b exp 0", ifa.coll); end
    ifa.ena = 1'b0; ifa.enb = 1'b0;
  endtask

  task automatic test_cross_port();
    ifa.ena = 1'b1; ifa.wea = 1'b1; ifa.addra = 12'h020; ifa.dina = 9'h00F;
    tick();
    ifa.dina = 9'h0F0;
    ifa.enb = 1'b1; ifa.web = 1'b0; ifa.addrb = 12'h020;
    tick();
    tests++; if (ifa.doutb !== 9'h00F) begin fails++; $display("FAIL xp_old got %h exp 00f", ifa.doutb); end
    tests++; if (ifa.coll !== ExpColl) begin fails++; $display("FAIL xp_coll got %b exp %b", ifa.coll, ExpColl); end
    ifa.ena = 1'b0; ifa.wea = 1'b0;
    tick();
    tests++; if (ifa.doutb !== 9'h0F0) begin fails++; $display("FAIL xp_new got %h exp 0f0", ifa.doutb); end
    tests++; if (ifa.coll !== 1'b0) begin fails++; $display("FAIL xp_coll_clr got %b exp 0", ifa.coll); end
    ifa.enb = 1'b0;
  endtask

  task automatic test_reset_mid();
    ifa.ena = 1'b1; ifa.wea = 1'b1; ifa.addra = 12'h001; ifa.dina = 9'h123; ifa.regcea = 1'b1;
    tick();
    ifa.enb = 1'b1; ifa.web = 1'b0; ifa.addrb = 12'h001;
    tick();
    tests++; if (ifa.Regdouta !== 9'h123) begin fails++; $display("FAIL rm_pre_reg got %h exp 123", ifa.Regdouta); end
    tests++; if (ifa.doutb !== 9'h123) begin fails++; $display("FAIL rm_pre_doutb got %h exp 123", ifa.doutb); end
    // Hold a write on 0x001 through the reset; it must be discarded.
    ifa.dina = 9'h000; ifa.enb = 1'b0; ifa.regcea = 1'b0;
    rsta_n = 1'b0;
    #1;
    tests++; if (ifa.douta !== 9'h000) begin fails++; $display("FAIL rm_douta got %h exp 000", ifa.douta); end
    tests++; if (ifa.doutb !== 9'h000) begin fails++; $display("FAIL rm_doutb got %h exp 000", ifa.doutb); end
    tests++; if (ifa.Regdouta !== 9'h000) begin fails++; $display("FAIL rm_rega got %h exp 000", ifa.Regdouta); end
    tests++; if (ifa.Regdoutb !== 9'h000) begin fails++; $display("FAIL rm_regb got %h exp 000", ifa.Regdoutb); end
    tests++; if (ifa.coll !== 1'b0) begin fails++; $display("FAIL rm_coll got %b exp 0", ifa.coll); end
    tick();
    tests++; if (ifa.douta !== 9'h000) begin fails++; $display("FAIL rm_held got %h exp 000", ifa.douta); end
    rsta_n = 1'b1;
    ifa.wea = 1'b0;
    tick();
    tests++; if (ifa.douta !== 9'h123) begin fails++; $display("FAIL rm_persist got %h exp 123", ifa.douta); end
    ifa.ena = 1'b0;
  endtask

  task automatic test_sweep();
    logic [31:0] exp_word;
    ifs.ena = 1'b1; ifs.wea = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ifs.addra = 4'(i);
      ifs.dina  = ~32'(i);
      tick();
    end
    ifs.ena = 1'b0; ifs.wea = 1'b0; ifs.enb = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ifs.addrb = 4'(i);
      exp_word  = ~32'(i);
      tick();
      tests++;
      if (ifs.doutb !== exp_word) begin
        fails++; $display("FAIL sweep_%0d got %h exp %h", i, ifs.doutb, exp_word);
      end
    end
    ifs.ena = 1'b1; ifs.addra = 4'd0; ifs.addrb = 4'd15;
    tick();
    tests++; if (ifs.douta !== 32'hFFFF_FFFF) begin fails++; $display("FAIL sw_addr0 got %h exp ffffffff", ifs.douta); end
    tests++; if (ifs.doutb !== 32'hFFFF_FFF0) begin fails++; $display("FAIL sw_addr15 got %h exp fffffff0", ifs.doutb); end
    ifs.ena = 1'b0; ifs.enb = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write_first();
    test_write_modes();
    test_dual_write();
    test_cross_port();
    test_reset_mid();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
